// File: rtl/combat_hit_sequencer_if.sv
// Collision, frame and life-counter signals in, hit pulses and fight status out.
// The life counter and sprite logic drive the master side; the referee owns the slave side.
interface combat_hit_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       hero_strike;
  logic       enemy_strike;
  logic [8:0] HealthH;
  logic [8:0] HealthE;
  logic       HitH;
  logic       HitE;
  logic       fight_active;
  logic       stunned;
  logic       ko;
  logic [1:0] winner;

  modport master (
    output frame_tick, start, hero_strike, enemy_strike, HealthH, HealthE,
    input  HitH, HitE, fight_active, stunned, ko, winner
  );

  modport slave (
    input  frame_tick, start, hero_strike, enemy_strike, HealthH, HealthE,
    output HitH, HitE, fight_active, stunned, ko, winner
  );
endinterface

// File: rtl/combat_hit_sequencer.sv
// Fight referee: strike edges -> arbitrated one-cycle hit pulses, frame-timed stun, KO detection.
// Define COMBO_DAMAGE_EN to add the combo timer that doubles repeat hits on the same target.
module combat_hit_sequencer #(
  parameter int STUN_FRAMES  = 8,
  parameter int KO_LIMIT     = 5,
  parameter int COMBO_FRAMES = 20
) (
  input  logic                  Clk,
  input  logic                  Reset,
  combat_hit_sequencer_if.slave bus
);
  localparam logic [5:0] STUN_LOAD = 6'(STUN_FRAMES);
  localparam logic [8:0] KO_LIM    = 9'(KO_LIMIT);

  generate
    if (STUN_FRAMES < 1 || STUN_FRAMES > 63 || COMBO_FRAMES < 1) begin : g_bad_param
      $error("combat_hit_sequencer: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    STUN  = 2'd2,
    KO    = 2'd3
  } state_t;

  state_t     state;
  logic [5:0] stun_cnt;
  logic       hero_q;
  logic       enemy_q;
  logic       hero_first;
  logic       hit_h;
  logic       hit_e;
  logic       fight_q;
  logic       stun_q;
  logic       ko_q;
  logic [1:0] winner_q;

  logic hero_edge;
  logic enemy_edge;
  logic contested;
  logic grant_h;
  logic grant_e;
  logic ko_h;
  logic ko_e;

  assign hero_edge  = bus.hero_strike  & ~hero_q;
  assign enemy_edge = bus.enemy_strike & ~enemy_q;
  assign contested  = hero_edge & enemy_edge;

  // A hero blow damages the enemy (HitE); an enemy blow damages the hero (HitH).
  assign grant_e = contested ? hero_first  : hero_edge;
  assign grant_h = contested ? ~hero_first : enemy_edge;

  assign ko_h = (bus.HealthH >= KO_LIM);
  assign ko_e = (bus.HealthE >= KO_LIM);

`ifdef COMBO_DAMAGE_EN
  localparam int            CW         = $clog2(COMBO_FRAMES + 1);
  localparam logic [CW-1:0] COMBO_LOAD = CW'(COMBO_FRAMES);

  logic [CW-1:0] combo_cnt;
  logic          last_e;
  logic          extra_h;
  logic          extra_e;
  logic          repeat_hit;

  assign repeat_hit = (combo_cnt != '0) && (last_e == grant_e);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      stun_cnt   <= '0;
      hero_q     <= 1'b0;
      enemy_q    <= 1'b0;
      hero_first <= 1'b1;
      hit_h      <= 1'b0;
      hit_e      <= 1'b0;
      fight_q    <= 1'b0;
      stun_q     <= 1'b0;
      ko_q       <= 1'b0;
      winner_q   <= 2'b00;
`ifdef COMBO_DAMAGE_EN
      combo_cnt  <= '0;
      last_e     <= 1'b0;
      extra_h    <= 1'b0;
      extra_e    <= 1'b0;
`endif
    end else begin
      hero_q  <= bus.hero_strike;
      enemy_q <= bus.enemy_strike;
      hit_h   <= 1'b0;
      hit_e   <= 1'b0;
`ifdef COMBO_DAMAGE_EN
      extra_h <= 1'b0;
      extra_e <= 1'b0;
      if (bus.frame_tick && combo_cnt != '0) begin
        combo_cnt <= combo_cnt - 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= FIGHT;
            fight_q <= 1'b1;
          end
        end

        FIGHT, STUN: begin
          // Knockout overrides any grant or stun expiry in the same cycle.
          if (ko_h || ko_e) begin
            state    <= KO;
            fight_q  <= 1'b0;
            stun_q   <= 1'b0;
            ko_q     <= 1'b1;
            winner_q <= {ko_h, ko_e};
          end else if (state == FIGHT) begin
            if (grant_h || grant_e) begin
              state    <= STUN;
              stun_q   <= 1'b1;
              stun_cnt <= STUN_LOAD;
              hit_h    <= grant_h;
              hit_e    <= grant_e;
              if (contested) begin
                hero_first <= ~hero_first;
              end
`ifdef COMBO_DAMAGE_EN
              combo_cnt <= COMBO_LOAD;
              last_e    <= grant_e;
              extra_h   <= grant_h & repeat_hit;
              extra_e   <= grant_e & repeat_hit;
`endif
            end
          end else begin
`ifdef COMBO_DAMAGE_EN
            hit_h <= extra_h;
            hit_e <= extra_e;
`endif
            if (bus.frame_tick) begin
              if (stun_cnt <= 6'd1) begin
                state    <= FIGHT;
                stun_q   <= 1'b0;
                stun_cnt <= '0;
              end else begin
                stun_cnt <= stun_cnt - 6'd1;
              end
            end
          end
        end

        KO: begin
          if (bus.start) begin
            state    <= IDLE;
            ko_q     <= 1'b0;
            winner_q <= 2'b00;
`ifdef COMBO_DAMAGE_EN
            combo_cnt <= '0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.HitH         = hit_h;
  assign bus.HitE         = hit_e;
  assign bus.fight_active = fight_q;
  assign bus.stunned      = stun_q;
  assign bus.ko           = ko_q;
  assign bus.winner       = winner_q;
endmodule

// File: tb/tb_combat_hit_sequencer.sv
// Bench for combat_hit_sequencer: fight-level model checked every cycle, a life-counter
// model closing the health loop, and directed scenarios with literal expectations.
module tb_combat_hit_sequencer;
  localparam int STUN_FRAMES  = 8;
  localparam int KO_LIMIT     = 5;
  localparam int COMBO_FRAMES = 20;

  localparam int P_IDLE  = 0;
  localparam int P_FIGHT = 1;
  localparam int P_STUN  = 2;
  localparam int P_KO    = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  combat_hit_sequencer_if bus ();

  combat_hit_sequencer #(
    .STUN_FRAMES (STUN_FRAMES),
    .KO_LIMIT    (KO_LIMIT),
    .COMBO_FRAMES(COMBO_FRAMES)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cnt_h  = 0;
  int cnt_e  = 0;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Life counter: damage registers one cycle after the pulse it counts.
  logic pend_h = 1'b0;
  logic pend_e = 1'b0;
  always @(negedge Clk) begin
    if (Reset) begin
      bus.HealthH = 9'd0;
      bus.HealthE = 9'd0;
      pend_h = 1'b0;
      pend_e = 1'b0;
    end else begin
      bus.HealthH = bus.HealthH + {8'd0, pend_h};
      bus.HealthE = bus.HealthE + {8'd0, pend_e};
      pend_h = bus.HitH;
      pend_e = bus.HitE;
    end
  end

  // Fight model: phase, frames of stun left, whose turn a tie goes to.
  int       m_phase = P_IDLE;
  int       m_stun_left = 0;
  int       m_combo_left = 0;
  int       m_extra = 0;
  int       m_pend = 0;
  bit       m_hero_next = 1'b1;
  bit       m_prev_h = 1'b0;
  bit       m_prev_e = 1'b0;
  bit       m_last_enemy = 1'b0;
  bit       armed = 1'b0;
  bit       x_hith = 1'b0;
  bit       x_hite = 1'b0;
  bit [1:0] x_win = 2'b00;
  bit       rise_h, rise_e, dead_h, dead_e, enemy_target;

  always @(posedge Clk) begin
    armed  = 1'b1;
    x_hith = 1'b0;
    x_hite = 1'b0;
    if (Reset) begin
      m_phase      = P_IDLE;
      m_stun_left  = 0;
      m_combo_left = 0;
      m_extra      = 0;
      m_hero_next  = 1'b1;
      m_prev_h     = 1'b0;
      m_prev_e     = 1'b0;
      x_win        = 2'b00;
    end else begin
      rise_h   = bus.hero_strike && !m_prev_h;
      rise_e   = bus.enemy_strike && !m_prev_e;
      m_prev_h = bus.hero_strike;
      m_prev_e = bus.enemy_strike;
      dead_h   = (bus.HealthH >= KO_LIMIT);
      dead_e   = (bus.HealthE >= KO_LIMIT);
      if (m_combo_left > 0 && bus.frame_tick) m_combo_left--;
      m_pend  = m_extra;
      m_extra = 0;
      if (m_phase == P_IDLE) begin
        if (bus.start) m_phase = P_FIGHT;
      end else if (m_phase == P_KO) begin
        if (bus.start) begin
          m_phase      = P_IDLE;
          x_win        = 2'b00;
          m_combo_left = 0;
        end
      end else if (dead_h || dead_e) begin
        m_phase = P_KO;
        x_win   = (dead_h && dead_e) ? 2'd3 : (dead_h ? 2'd2 : 2'd1);
      end else if (m_phase == P_FIGHT) begin
        if (rise_h || rise_e) begin
          enemy_target = (rise_h && rise_e) ? m_hero_next : rise_h;
          if (rise_h && rise_e) m_hero_next = !m_hero_next;
          x_hite      = enemy_target;
          x_hith      = !enemy_target;
          m_phase     = P_STUN;
          m_stun_left = STUN_FRAMES;
`ifdef COMBO_DAMAGE_EN
          if (m_combo_left > 0 && m_last_enemy == enemy_target) m_extra = enemy_target ? 2 : 1;
          m_combo_left = COMBO_FRAMES;
          m_last_enemy = enemy_target;
`endif
        end
      end else begin
        if (m_pend == 1) x_hith = 1'b1;
        if (m_pend == 2) x_hite = 1'b1;
        if (bus.frame_tick) begin
          m_stun_left--;
          if (m_stun_left <= 0) m_phase = P_FIGHT;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("HitH", {8'd0, bus.HitH}, {8'd0, x_hith});
      check("HitE", {8'd0, bus.HitE}, {8'd0, x_hite});
      check("fight_active", {8'd0, bus.fight_active},
            {8'd0, (m_phase == P_FIGHT || m_phase == P_STUN)});
      check("stunned", {8'd0, bus.stunned}, {8'd0, (m_phase == P_STUN)});
      check("ko", {8'd0, bus.ko}, {8'd0, (m_phase == P_KO)});
      check("winner", {7'd0, bus.winner}, {7'd0, x_win});
      if (bus.HitH) cnt_h++;
      if (bus.HitE) cnt_e++;
    end
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
      step();
    end
  endtask

  // Wait out stun; with combos enabled also let the combo window lapse.
  task automatic recover();
    frames(STUN_FRAMES);
`ifdef COMBO_DAMAGE_EN
    frames(COMBO_FRAMES + 1 - STUN_FRAMES);
`endif
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    step();
    Reset = 1'b0;
  endtask

  int base_h, base_e;
  bit [0:2] tie_to_enemy;

  initial begin
    bus.frame_tick   = 1'b0;
    bus.start        = 1'b0;
    bus.hero_strike  = 1'b0;
    bus.enemy_strike = 1'b0;
    tie_to_enemy     = 3'b101;

    do_reset();
    check("reset_fight", {8'd0, bus.fight_active}, 9'd0);
    check("reset_ko", {8'd0, bus.ko}, 9'd0);
    check("reset_winner", {7'd0, bus.winner}, 9'd0);

    // Basic hit and stun expiry after exactly STUN_FRAMES ticks.
    pulse_start();
    check("start_fight", {8'd0, bus.fight_active}, 9'd1);
    bus.enemy_strike = 1'b1;
    step();
    check("basic_HitH", {8'd0, bus.HitH}, 9'd1);
    check("basic_stunned", {8'd0, bus.stunned}, 9'd1);
    step();
    check("basic_HitH_one_cycle", {8'd0, bus.HitH}, 9'd0);
    bus.enemy_strike = 1'b0;
    frames(7);
    check("stun_before_8th", {8'd0, bus.stunned}, 9'd1);
    frames(1);
    check("stun_after_8th", {8'd0, bus.stunned}, 9'd0);
    check("fight_after_stun", {8'd0, bus.fight_active}, 9'd1);
    check("basic_count", 9'(cnt_h), 9'd1);

    // Held hero strike spanning stun expiry: one pulse only, a fresh rise gives another.
    bus.hero_strike = 1'b1;
    for (int i = 0; i < 500; i++) begin
      bus.frame_tick = (i % 10 == 5);
      step();
    end
    bus.frame_tick = 1'b0;
    check("held_count", 9'(cnt_e), 9'd1);
    bus.hero_strike = 1'b0;
    step();
    bus.hero_strike = 1'b1;
    step();
    bus.hero_strike = 1'b0;
    step();
    check("held_rerise_count", 9'(cnt_e), 9'd2);
    recover();

    // Simultaneous rises: hero-first, then alternating; the loser gets nothing.
    for (int k = 0; k < 3; k++) begin
      bus.hero_strike  = 1'b1;
      bus.enemy_strike = 1'b1;
      step();
      check("tie_HitE", {8'd0, bus.HitE}, {8'd0, tie_to_enemy[k]});
      check("tie_HitH", {8'd0, bus.HitH}, {8'd0, !tie_to_enemy[k]});
      bus.hero_strike  = 1'b0;
      bus.enemy_strike = 1'b0;
      recover();
    end
    check("tie_count_e", 9'(cnt_e), 9'd4);
    check("tie_count_h", 9'(cnt_h), 9'd2);

    // Stun immunity: five more enemy edges while stunned change nothing.
    bus.enemy_strike = 1'b1;
    step();
    check("immune_grant", {8'd0, bus.HitH}, 9'd1);
    for (int k = 0; k < 5; k++) begin
      bus.enemy_strike = 1'b0;
      step();
      bus.enemy_strike = 1'b1;
      step();
    end
    bus.enemy_strike = 1'b0;
    step();
    check("immune_count", 9'(cnt_h), 9'd3);
    check("immune_HealthH", bus.HealthH, 9'd3);
    recover();

    // Fifth hero blow knocks the enemy out: hero wins two cycles after the pulse.
    bus.hero_strike = 1'b1;
    step();
    check("ko_e_pulse", {8'd0, bus.HitE}, 9'd1);
    bus.hero_strike = 1'b0;
    step();
    check("ko_e_not_yet", {8'd0, bus.ko}, 9'd0);
    step();
    check("ko_e_ko", {8'd0, bus.ko}, 9'd1);
    check("ko_e_winner", {7'd0, bus.winner}, 9'd1);
    check("ko_e_HealthE", bus.HealthE, 9'd5);
    pulse_start();
    check("ko_e_idle_winner", {7'd0, bus.winner}, 9'd0);
    check("ko_e_idle_ko", {8'd0, bus.ko}, 9'd0);

    // Fresh fight: five enemy blows, enemy wins, later strikes ignored.
    do_reset();
    check("reset_HealthH", bus.HealthH, 9'd0);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      bus.enemy_strike = 1'b1;
      step();
      check("ko_h_pulse", {8'd0, bus.HitH}, 9'd1);
      bus.enemy_strike = 1'b0;
      if (k < 4) recover();
    end
    step();
    check("ko_h_not_yet", {8'd0, bus.ko}, 9'd0);
    step();
    check("ko_h_ko", {8'd0, bus.ko}, 9'd1);
    check("ko_h_winner", {7'd0, bus.winner}, 9'd2);
    check("ko_h_HealthH", bus.HealthH, 9'd5);
    base_h = cnt_h;
    base_e = cnt_e;
    bus.hero_strike = 1'b1;
    step();
    bus.hero_strike  = 1'b0;
    bus.enemy_strike = 1'b1;
    step();
    bus.enemy_strike = 1'b0;
    step();
    check("ko_quiet_h", 9'(cnt_h - base_h), 9'd0);
    check("ko_quiet_e", 9'(cnt_e - base_e), 9'd0);
    pulse_start();
    check("ko_h_idle_winner", {7'd0, bus.winner}, 9'd0);
    check("ko_h_idle_fight", {8'd0, bus.fight_active}, 9'd0);

    // Reset with four frames of stun left aborts straight to IDLE.
    do_reset();
    pulse_start();
    bus.enemy_strike = 1'b1;
    step();
    bus.enemy_strike = 1'b0;
    frames(4);
    check("mid_stun_stunned", {8'd0, bus.stunned}, 9'd1);
    Reset = 1'b1;
    step();
    check("abort_fight", {8'd0, bus.fight_active}, 9'd0);
    check("abort_stunned", {8'd0, bus.stunned}, 9'd0);
    check("abort_HitH", {8'd0, bus.HitH}, 9'd0);
    Reset = 1'b0;
    step();
    check("post_reset_HitH", {8'd0, bus.HitH}, 9'd0);
    check("post_reset_fight", {8'd0, bus.fight_active}, 9'd0);

`ifdef COMBO_DAMAGE_EN
    // Same-target grant inside the combo window gives a two-cycle pulse.
    do_reset();
    pulse_start();
    bus.hero_strike = 1'b1;
    step();
    bus.hero_strike = 1'b0;
    check("combo_first", {8'd0, bus.HitE}, 9'd1);
    frames(STUN_FRAMES);
    bus.hero_strike = 1'b1;
    step();
    bus.hero_strike = 1'b0;
    check("combo_cycle1", {8'd0, bus.HitE}, 9'd1);
    step();
    check("combo_cycle2", {8'd0, bus.HitE}, 9'd1);
    step();
    check("combo_done", {8'd0, bus.HitE}, 9'd0);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
